// File: rtl/tree_walker.sv
// Decision-tree walker: a configurable node table plus one time-shared signed compare.
// Each walk starts at node 0 and returns the class of the leaf it reaches, or an error on abort.
module tree_walker #(
    parameter int N_NODES    = 16,
    parameter int N_FEATURES = 8,
    parameter int DATA_W     = 32,
    parameter int CLASS_W    = 8,
    parameter int MAX_DEPTH  = 16,
    parameter int NI         = $clog2(N_NODES),
    parameter int FI         = $clog2(N_FEATURES),
    parameter int DW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           io_cfg_valid,
    output logic                           io_cfg_ready,
    input  logic [NI-1:0]                  io_cfg_bits_addr,
    input  logic [FI-1:0]                  io_cfg_bits_feature_index,
    input  logic [DATA_W-1:0]              io_cfg_bits_threshold,
    input  logic [NI-1:0]                  io_cfg_bits_left,
    input  logic [NI-1:0]                  io_cfg_bits_right,
    input  logic                           io_cfg_bits_leaf,
    input  logic [CLASS_W-1:0]             io_cfg_bits_class,
    input  logic                           io_req_valid,
    output logic                           io_req_ready,
    input  logic [N_FEATURES*DATA_W-1:0]   io_req_bits_features,
    output logic                           io_resp_valid,
    input  logic                           io_resp_ready,
    output logic [CLASS_W-1:0]             io_resp_bits_class,
    output logic [DW-1:0]                  io_resp_bits_depth,
    output logic                           io_resp_bits_error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                  state;
    logic [NI-1:0]               node;
    logic [DW-1:0]               depth;
    logic [N_FEATURES*DATA_W-1:0] features_q;
    logic [DATA_W-1:0]           feat_arr [N_FEATURES];

    logic [FI-1:0]               t_fidx  [N_NODES];
    logic [DATA_W-1:0]           t_thr   [N_NODES];
    logic [NI-1:0]               t_left  [N_NODES];
    logic [NI-1:0]               t_right [N_NODES];
    logic                        t_leaf  [N_NODES];
    logic [CLASS_W-1:0]          t_class [N_NODES];

    logic                        node_ok;
    logic [NI-1:0]               rd;
    logic [FI-1:0]               cur_fidx;
    logic [DATA_W-1:0]           cur_thr;
    logic [NI-1:0]               cur_left;
    logic [NI-1:0]               cur_right;
    logic                        cur_leaf;
    logic [CLASS_W-1:0]          cur_class;
    logic                        fidx_ok;
    logic [FI-1:0]               fsel;
    logic [DATA_W-1:0]           feat;
    logic                        go_left;
    logic [NI-1:0]               next_node;
    logic                        cfg_fire;

    assign io_cfg_ready = (state == S_IDLE);
    assign io_req_ready = (state == S_IDLE);
    assign cfg_fire     = io_cfg_valid && (state == S_IDLE) && (32'(io_cfg_bits_addr) < N_NODES);

    for (genvar g = 0; g < N_FEATURES; g++) begin : g_feat
        assign feat_arr[g] = features_q[g*DATA_W +: DATA_W];
    end

    always_comb begin
        node_ok   = (32'(node) < N_NODES);
        rd        = node_ok ? node : '0;
        cur_fidx  = t_fidx[rd];
        cur_thr   = t_thr[rd];
        cur_left  = t_left[rd];
        cur_right = t_right[rd];
        cur_leaf  = t_leaf[rd];
        cur_class = t_class[rd];
        fidx_ok   = (32'(cur_fidx) < N_FEATURES);
        fsel      = fidx_ok ? cur_fidx : '0;
        feat      = feat_arr[fsel];
        go_left   = ($signed(feat) <= $signed(cur_thr));
        next_node = go_left ? cur_left : cur_right;
    end

    // Node table; writes only land while idle so a walk never sees a half-updated tree.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_NODES; i++) begin
                t_fidx[i]  <= '0;
                t_thr[i]   <= '0;
                t_left[i]  <= '0;
                t_right[i] <= '0;
                t_leaf[i]  <= 1'b0;
                t_class[i] <= '0;
            end
        end else if (cfg_fire) begin
            t_fidx[io_cfg_bits_addr]  <= io_cfg_bits_feature_index;
            t_thr[io_cfg_bits_addr]   <= io_cfg_bits_threshold;
            t_left[io_cfg_bits_addr]  <= io_cfg_bits_left;
            t_right[io_cfg_bits_addr] <= io_cfg_bits_right;
            t_leaf[io_cfg_bits_addr]  <= io_cfg_bits_leaf;
            t_class[io_cfg_bits_addr] <= io_cfg_bits_class;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            node               <= '0;
            depth              <= '0;
            features_q         <= '0;
            io_resp_valid      <= 1'b0;
            io_resp_bits_class <= '0;
            io_resp_bits_depth <= '0;
            io_resp_bits_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io_req_valid) begin
                        features_q <= io_req_bits_features;
                        node       <= '0;
                        depth      <= '0;
                        state      <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (!node_ok || (!cur_leaf && (!fidx_ok || depth == DW'(MAX_DEPTH)))) begin
                        io_resp_bits_class <= '0;
                        io_resp_bits_depth <= depth;
                        io_resp_bits_error <= 1'b1;
                        state              <= S_DONE;
                    end else if (cur_leaf) begin
                        io_resp_bits_class <= cur_class;
                        io_resp_bits_depth <= depth;
                        io_resp_bits_error <= 1'b0;
                        state              <= S_DONE;
                    end else begin
                        node  <= next_node;
                        depth <= depth + 1'b1;
                    end
                end
                S_DONE: begin
                    // Valid rises one edge after the result bits settle, then holds until taken.
                    if (!io_resp_valid) begin
                        io_resp_valid <= 1'b1;
                    end else if (io_resp_ready) begin
                        io_resp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
